// File: rtl/comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM state and packed result flags.
package comparator_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} cmp_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

endpackage

// File: rtl/comparator_chunk.sv
// Combinational W-bit chunk compare: equality via comparator_eq, plus unsigned less-than.
module comparator_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         chunk_eq,
  output logic         chunk_lt
);

  comparator_eq #(.N(W)) u_eq (
    .a  (a),
    .b  (b),
    .eq (chunk_eq)
  );

  assign chunk_lt = (a < b);

endmodule

// File: rtl/comparator_eq.sv
// Combinational N-bit equality comparator; reused as the equality leg of each chunk compare.
module comparator_eq #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/comparator_serial.sv
// Multi-cycle MSB-first N-bit comparator, W bits per cycle, start/ready/done handshake.
// Optional signed mode is enabled by defining COMPARATOR_SIGNED_EN (adds port is_signed).
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
  input  logic         is_signed,
`endif
  output logic         ready,
  output logic         done,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  localparam int STEPS = N / W;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0] STEPS_CNT = STEPS[CW-1:0];
  localparam logic [CW-1:0] LAST_CNT  = CW'(1);

  cmp_state_t    state_reg;
  logic [N-1:0]  a_sh_reg, b_sh_reg;
  logic [CW-1:0] count_reg;
  logic          decided_reg, lt_n_reg, gt_n_reg;
  logic          ready_reg, done_reg;
  cmp_result_t   res_reg;

  logic [N-1:0]  a_cap, b_cap;
  logic          chunk_eq, chunk_lt;
  logic          decided_next, lt_next, gt_next;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef COMPARATOR_SIGNED_EN
  always_comb begin
    a_cap = a;
    b_cap = b;
    if (is_signed) begin
      a_cap[N-1] = ~a[N-1];
      b_cap[N-1] = ~b[N-1];
    end
  end
`else
  assign a_cap = a;
  assign b_cap = b;
`endif

  comparator_chunk #(.W(W)) u_chunk (
    .a        (a_sh_reg[N-1 -: W]),
    .b        (b_sh_reg[N-1 -: W]),
    .chunk_eq (chunk_eq),
    .chunk_lt (chunk_lt)
  );

  // The first unequal chunk decides; later chunks cannot override it.
  always_comb begin
    decided_next = decided_reg | ~chunk_eq;
    lt_next      = decided_reg ? lt_n_reg : (~chunk_eq &  chunk_lt);
    gt_next      = decided_reg ? gt_n_reg : (~chunk_eq & ~chunk_lt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      a_sh_reg    <= '0;
      b_sh_reg    <= '0;
      count_reg   <= '0;
      decided_reg <= 1'b0;
      lt_n_reg    <= 1'b0;
      gt_n_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      done_reg    <= 1'b0;
      res_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_sh_reg    <= a_cap;
            b_sh_reg    <= b_cap;
            count_reg   <= STEPS_CNT;
            decided_reg <= 1'b0;
            lt_n_reg    <= 1'b0;
            gt_n_reg    <= 1'b0;
            ready_reg   <= 1'b0;
            state_reg   <= S_BUSY;
          end
        end
        S_BUSY: begin
          a_sh_reg    <= a_sh_reg << W;
          b_sh_reg    <= b_sh_reg << W;
          count_reg   <= count_reg - 1'b1;
          decided_reg <= decided_next;
          lt_n_reg    <= lt_next;
          gt_n_reg    <= gt_next;
          if (count_reg == LAST_CNT) begin
            res_reg   <= '{eq: ~decided_next, lt: lt_next, gt: gt_next};
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign done  = done_reg;
  assign eq    = res_reg.eq;
  assign lt    = res_reg.lt;
  assign gt    = res_reg.gt;

endmodule

// File: tb/tb_comparator_serial.sv
// Scoreboard bench for comparator_serial (N=32, W=4): stimulus pushes expected results,
// a negedge monitor pops and compares on each done. Honours COMPARATOR_SIGNED_EN.
module tb_comparator_serial;

  localparam int N     = 32;
  localparam int W     = 4;
  localparam int STEPS = N / W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
`ifdef COMPARATOR_SIGNED_EN
  logic         is_signed;
`endif
  logic         ready, done, eq, lt, gt;

  comparator_serial #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef COMPARATOR_SIGNED_EN
    .is_signed (is_signed),
`endif
    .ready     (ready),
    .done      (done),
    .eq        (eq),
    .lt        (lt),
    .gt        (gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   res;
    int           accept_edge;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sgn;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer ordering of the two operands, returned as {eq,lt,gt}.
  function automatic logic [2:0] ref_cmp(logic [N-1:0] x, logic [N-1:0] y, logic sgn);
    logic e, l, g;
    e = (x == y);
    if (sgn) begin
      l = ($signed(x) < $signed(y));
      g = ($signed(x) > $signed(y));
    end else begin
      l = (x < y);
      g = (x > y);
    end
    return {e, l, g};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic cur_sgn();
`ifdef COMPARATOR_SIGNED_EN
    return is_signed;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: records accepted requests and checks every done against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (start && ready) begin
        exp_t e;
        e.res         = ref_cmp(a, b, cur_sgn());
        e.accept_edge = cyc + 1;
        e.a           = a;
        e.b           = b;
        e.sgn         = cur_sgn();
        q.push_back(e);
      end
      if (done) begin
        check("done_pulse", {31'd0, prev_done}, 32'd0);
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", {29'd0, eq, lt, gt}, {29'd0, e.res});
          check("latency", cyc - e.accept_edge, STEPS);
          $display("op a=%08h b=%08h signed=%0b -> eq=%0b lt=%0b gt=%0b (expected %03b)",
                   e.a, e.b, e.sgn, eq, lt, gt, e.res);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic issue(logic [N-1:0] x, logic [N-1:0] y, logic sgn);
    @(posedge clk); #1;
    start = 1'b1;
    a     = x;
    b     = y;
`ifdef COMPARATOR_SIGNED_EN
    is_signed = sgn;
`else
    if (sgn) $display("note: signed request issued in unsigned build");
`endif
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_drain_timeout"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef COMPARATOR_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done",  {31'd0, done},  32'd0);
    check("reset_flags", {29'd0, eq, lt, gt}, 32'd0);

    // Equal zeros; ready must drop once the op is accepted.
    issue('0, '0, 1'b0);
    check("busy_ready_low", {31'd0, ready}, 32'd0);
    drain("zero");

    // Least-significant chunk decides; no sticky leak between ops.
    issue(32'd1, 32'd0, 1'b0);
    drain("lsb_gt");
    issue(32'h0000_0010, 32'h0000_0011, 1'b0);
    drain("lsb_lt");

    // Sign-bit boundary.
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    drain("msb_unsigned");
`ifdef COMPARATOR_SIGNED_EN
    issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    drain("msb_signed");
`endif

    // Start during BUSY is ignored.
    issue(32'd5, 32'd9, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = '0; b = '0;
    @(posedge clk); #1;
    start = 1'b0;
    drain("busy_ignore");

    // Random single ops, biased to differ in one chunk only.
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] x, y;
      x = $urandom;
      y = (i % 2 == 0) ? (x ^ (32'(1) << $urandom_range(0, N - 1))) : $urandom;
      issue(x, y, 1'(i / 4));
      drain("random");
    end

    // Reset mid-op: outputs clear at once and the in-flight op never completes.
    issue($urandom, $urandom, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_done",  {31'd0, done},  32'd0);
    check("midrst_flags", {29'd0, eq, lt, gt}, 32'd0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("midrst_flags_after", {29'd0, eq, lt, gt}, 32'd0);

    // start held high: back-to-back ops with operands changing every cycle.
    @(posedge clk); #1;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
`ifdef COMPARATOR_SIGNED_EN
      is_signed = 1'($urandom_range(0, 1));
`endif
      @(posedge clk); #1;
    end
    start = 1'b0;
    drain("held_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
